// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: non-mem ops pass to WB, loads/stores go through a one-at-a-time memory handshake (optional MEM_TIMEOUT_EN abort).
// Latency: non-mem op 1 cycle to wb_valid; memory op 2 cycles minimum (accept edge + ack edge).
// Backpressure: stall is high for every BUSY cycle; EX must hold its inputs until stall drops.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic [3:0]  dst_reg,
    input  logic        wb_en_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic [3:0]  wb_reg,
    output logic        wb_en,
    output logic        mem_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [3:0]  dst;
        logic        is_load;
    } op_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
        $error("mem_stage_ctrl: TIMEOUT_CYCLES must be within 1..255");
    end

    state_t      state_q, state_d;
    op_t         op_q;
    logic        pass_thru, accept_mem, done_ack, done_tmo, tmo_hit;
    logic        wb_valid_q, wb_en_q;
    logic [15:0] wb_data_q;
    logic [3:0]  wb_reg_q;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;
    logic       mem_err_q;

    // cnt_q counts completed ack-less BUSY cycles; the last allowed one triggers the abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            mem_err_q <= done_tmo;
            if (accept_mem)
                cnt_q <= '0;
            else if (state_q == BUSY && !mem_ack)
                cnt_q <= cnt_q + 8'd1;
        end
    end

    assign tmo_hit = (cnt_q == TO_LAST);
    assign mem_err = mem_err_q;
`else
    assign tmo_hit = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // mem_ack outranks the timeout so a late-but-present ack still completes normally
    always_comb begin
        state_d    = state_q;
        pass_thru  = 1'b0;
        accept_mem = 1'b0;
        done_ack   = 1'b0;
        done_tmo   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (is_load || is_store) begin
                        accept_mem = 1'b1;
                        state_d    = BUSY;
                    end else begin
                        pass_thru  = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    done_ack = 1'b1;
                    state_d  = IDLE;
                end else if (tmo_hit) begin
                    done_tmo = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_reg_q   <= '0;
            wb_en_q    <= 1'b0;
        end else begin
            wb_valid_q <= pass_thru | done_ack | done_tmo;
            // a load flag wins when both op bits are set
            if (accept_mem)
                op_q <= '{addr: addr, wdata: wdata, dst: dst_reg, is_load: is_load};
            if (pass_thru) begin
                wb_data_q <= wdata;
                wb_reg_q  <= dst_reg;
                wb_en_q   <= wb_en_in;
            end else if (done_ack) begin
                wb_data_q <= op_q.is_load ? mem_rdata : 16'h0000;
                wb_reg_q  <= op_q.dst;
                wb_en_q   <= op_q.is_load;
            end else if (done_tmo) begin
                wb_data_q <= 16'h0000;
                wb_reg_q  <= op_q.dst;
                wb_en_q   <= 1'b0;
            end
        end
    end

    assign stall     = (state_q == BUSY);
    assign mem_req   = (state_q == BUSY);
    assign mem_we    = (state_q == BUSY) && !op_q.is_load;
    assign mem_addr  = op_q.addr & 16'hFFFE;
    assign mem_wdata = op_q.wdata;
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign wb_reg    = wb_reg_q;
    assign wb_en     = wb_en_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: pass-through, load, store, ack corner cases, reset mid-op, timeout.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, is_load, is_store, wb_en_in, mem_ack;
    logic [15:0] addr, wdata, mem_rdata;
    logic [3:0]  dst_reg;
    logic        stall, mem_req, mem_we, wb_valid, wb_en, mem_err;
    logic [15:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  wb_reg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .is_load(is_load),
        .is_store(is_store), .addr(addr), .wdata(wdata), .dst_reg(dst_reg),
        .wb_en_in(wb_en_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_reg(wb_reg), .wb_en(wb_en), .mem_err(mem_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic [15:0] a,
                         input logic [15:0] d, input logic [3:0] r, input logic we);
        valid_in = v; is_load = ld; is_store = st; addr = a; wdata = d; dst_reg = r; wb_en_in = we;
    endtask

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_wb_data", wb_data, 16'h0000);
        chk("rst_mem_err", mem_err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // non-memory op, latency 1
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234, 4'd3, 1'b1);
        tick();
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_data", wb_data, 16'h1234);
        chk("alu_wb_reg", wb_reg, 4'd3);
        chk("alu_wb_en", wb_en, 1);
        chk("alu_stall", stall, 0);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0);
        tick();
        chk("alu_pulse_end", wb_valid, 0);
        chk("alu_hold_data", wb_data, 16'h1234);

        // ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        chk("idle_ack_wb_valid", wb_valid, 0);
        chk("idle_ack_stall", stall, 0);
        chk("idle_ack_wb_data", wb_data, 16'h1234);

        // load at odd address, ack in 4th BUSY cycle; new valid_in during BUSY ignored
        drive(1'b1, 1'b1, 1'b0, 16'h0041, 16'h0000, 4'd5, 1'b1);
        tick();
        chk("ld_b1_stall", stall, 1);
        chk("ld_b1_req", mem_req, 1);
        chk("ld_b1_we", mem_we, 0);
        chk("ld_b1_addr", mem_addr, 16'h0040);
        drive(1'b1, 1'b0, 1'b1, 16'h0F00, 16'h7777, 4'd9, 1'b0);
        tick();
        chk("ld_b2_stall", stall, 1);
        chk("ld_b2_addr", mem_addr, 16'h0040);
        chk("ld_b2_we", mem_we, 0);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0);
        tick();
        chk("ld_b3_stall", stall, 1);
        tick();
        chk("ld_b4_stall", stall, 1);
        chk("ld_b4_wb_valid", wb_valid, 0);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_data", wb_data, 16'hBEEF);
        chk("ld_wb_en", wb_en, 1);
        chk("ld_wb_reg", wb_reg, 4'd5);
        chk("ld_done_stall", stall, 0);
        chk("ld_done_req", mem_req, 0);

        // back-to-back store, ack in first BUSY cycle
        drive(1'b1, 1'b0, 1'b1, 16'h0100, 16'hA5A5, 4'd2, 1'b0);
        tick();
        chk("st_stall", stall, 1);
        chk("st_we", mem_we, 1);
        chk("st_wdata", mem_wdata, 16'hA5A5);
        chk("st_addr", mem_addr, 16'h0100);
        chk("st_pulse_gap", wb_valid, 0);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("st_wb_valid", wb_valid, 1);
        chk("st_wb_en", wb_en, 0);
        chk("st_wb_data", wb_data, 16'h0000);
        chk("st_stall_done", stall, 0);

        // load+store together behaves as a load
        drive(1'b1, 1'b1, 1'b1, 16'h0203, 16'h4444, 4'd7, 1'b1);
        tick();
        chk("both_we", mem_we, 0);
        chk("both_addr", mem_addr, 16'h0202);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0);
        mem_ack = 1'b1; mem_rdata = 16'h1357;
        tick();
        mem_ack = 1'b0;
        chk("both_wb_data", wb_data, 16'h1357);
        chk("both_wb_en", wb_en, 1);
        chk("both_wb_reg", wb_reg, 4'd7);

        // reset during BUSY abandons the op
        drive(1'b1, 1'b1, 1'b0, 16'h0080, 16'h0000, 4'd4, 1'b1);
        tick();
        chk("rb_req_before", mem_req, 1);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("rb_req_async", mem_req, 0);
        chk("rb_stall_async", stall, 0);
        chk("rb_wb_data_async", wb_data, 16'h0000);
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        tick();
        mem_ack = 1'b0;
        chk("rb_late_ack_wb_valid", wb_valid, 0);
        chk("rb_late_ack_stall", stall, 0);
        tick();
        chk("rb_late_ack_wb_valid2", wb_valid, 0);

        // load with no ack: abort after 4 BUSY cycles, or wait forever
        drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 4'd6, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0);
        chk("to_b1_stall", stall, 1);
`ifdef MEM_TIMEOUT_EN
        tick();
        tick();
        tick();
        chk("to_b4_stall", stall, 1);
        chk("to_b4_err", mem_err, 0);
        tick();
        chk("to_err", mem_err, 1);
        chk("to_wb_valid", wb_valid, 1);
        chk("to_wb_en", wb_en, 0);
        chk("to_stall", stall, 0);
        tick();
        chk("to_err_pulse", mem_err, 0);
        chk("to_wb_pulse", wb_valid, 0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("noto_stall", stall, 1);
            chk("noto_err", mem_err, 0);
        end
        chk("noto_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 16'h2468;
        tick();
        mem_ack = 1'b0;
        chk("noto_late_ack", wb_data, 16'h2468);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
